fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage; next generation of the basic PC-increment fetch.
- Owns the PC and issues read requests to main memory over a req/ack + rvalid handshake, with at most one outstanding request.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO feeding decode.
- Supports decode back-pressure (stall) and branch/jump redirect with flush of the FIFO and of any in-flight response.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width
DEPTH, 4, instruction FIFO entries (power of 2, >=2)
RESET_PC, 0, PC value loaded on reset
PC_INC, 4, byte increment per instruction

Ports:
clk_in  in  1  clock, all state on rising edge
rst_n_in  in  1  asynchronous active-low reset
stall_in  in  1  decode cannot accept; holds FIFO head
redirect_in  in  1  branch/jump taken; load new PC and flush
redirect_pc_in  in  ADDR_W  redirect target
mem_req_out  out  1  read request valid
mem_addr_out  out  ADDR_W  request address (PC)
mem_rw_out  out  1  always 0 (read)
mem_access_size_out  out  2  always 2'b10 (word)
mem_ack_in  in  1  memory accepts request this cycle
mem_rvalid_in  in  1  read data valid
mem_rdata_in  in  DATA_W  read data
insn_valid_out  out  1  FIFO head valid
insn_out  out  DATA_W  instruction at FIFO head
pc_out  out  ADDR_W  PC of head instruction
next_pc_out  out  ADDR_W  pc_out + PC_INC
fifo_count_out  out  log2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (async, rst_n_in=0): pc=RESET_PC; FSM=IDLE; FIFO empty; mem_req_out=0, mem_addr_out=RESET_PC, insn_valid_out=0, insn_out=0, pc_out=0, next_pc_out=PC_INC, fifo_count_out=0. mem_rw_out=0 and mem_access_size_out=2'b10 at all times, including reset. Reset mid-transaction abandons the request; memory side must tolerate this.
- FSM states:
  - IDLE: move to REQ when fifo_count + 1 <= DEPTH (space for the response).
  - REQ: mem_req_out=1, mem_addr_out=pc held stable. On mem_ack_in, pc<=pc+PC_INC (mod 2^ADDR_W, wraps) and go to WAIT.
  - WAIT: on mem_rvalid_in, push {mem_rdata_in, request PC} into FIFO. Go to REQ if space remains after the push, else IDLE.
  - DROP: on mem_rvalid_in, discard the data and go to IDLE (next cycle REQ at the new pc).
- Space check counts the in-flight response, so the FIFO never overflows. rvalid in IDLE/REQ is ignored.
- Request latency: earliest request one cycle after reset deassert. Response accepted the cycle rvalid is seen. Head visible on insn_* the cycle after the push; an empty-FIFO bypass is not used.
- Dequeue: pop when insn_valid_out=1 and stall_in=0. Push and pop in the same cycle leave the count unchanged. Pop on empty is ignored.
- Redirect (highest priority, same-cycle effect at the next edge):
  - pc<=redirect_pc_in; FIFO flushed (count=0, insn_valid_out=0).
  - WAIT -> DROP; REQ -> REQ with the new address (a request acked that same cycle is treated as in-flight, go DROP); IDLE -> IDLE.
  - Simultaneous rvalid in WAIT: data is discarded, go IDLE.
  - Redirect while in DROP: stay in DROP, pc updated.
  - Redirect overrides stall_in and any pop.
- FIFO pointers wrap modulo DEPTH; fifo_count_out ranges 0..DEPTH.
- Stall does not stop fetching until the FIFO is full.

Test Plan:
- Reset, RESET_PC=0x100, ack and 1-cycle rvalid always, stall_in=0 -> requests 0x100, 0x104, 0x108 in order; insn_out/pc_out stream matches, next_pc_out = pc_out+4.
- stall_in=1 for 20 cycles, DEPTH=4 -> fifo_count_out saturates at 4, mem_req_out low while full. Release stall -> 4 pops in 4 cycles in PC order, fetching resumes.
- Redirect to 0x2000 while in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> data discarded, FIFO empty, next request address 0x2000.
- Redirect coincident with mem_ack_in and with rvalid in WAIT -> no stale instruction ever appears on insn_out. Next head pc_out=redirect target.
- PC near 2^32-4 -> request at 0xFFFFFFFC then 0x00000000 (wrap).
- rst_n_in asserted mid-WAIT, asynchronously between edges -> outputs hit reset values immediately; restart fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack+rvalid bus
// and queues {insn, pc} pairs in a small FIFO for decode; supports stall/redirect.
// Ports: clk_in/rst_n_in; stall_in, redirect_in, redirect_pc_in from decode/branch;
//   mem_req_out/mem_addr_out/mem_rw_out/mem_access_size_out/mem_ack_in/
//   mem_rvalid_in/mem_rdata_in to memory; insn_valid_out/insn_out/pc_out/
//   next_pc_out/fifo_count_out to decode.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_INC = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic stall_in,
  input  logic redirect_in,
  input  logic [ADDR_W-1:0] redirect_pc_in,
  output logic mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic mem_rw_out,
  output logic [1:0] mem_access_size_out,
  input  logic mem_ack_in,
  input  logic mem_rvalid_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic insn_valid_out,
  output logic [DATA_W-1:0] insn_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] next_pc_out,
  output logic [$clog2(DEPTH):0] fifo_count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] INC_C = ADDR_W'(PC_INC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic [DATA_W-1:0] r_fifo_insn [DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;

  logic w_push;
  logic w_pop;
  logic w_valid;
  logic [CNT_W-1:0] w_pop_c;
  logic [CNT_W-1:0] w_push_c;
  logic [CNT_W-1:0] w_cnt_after;

  assign w_valid = (r_cnt != '0);
  assign w_push = (r_state == S_WAIT) && mem_rvalid_in && !redirect_in;
  assign w_pop = w_valid && !stall_in && !redirect_in;
  assign w_pop_c = {{(CNT_W-1){1'b0}}, w_pop};
  assign w_push_c = {{(CNT_W-1){1'b0}}, w_push};
  // Occupancy once the response now arriving in WAIT is written.
  assign w_cnt_after = r_cnt + CNT_W'(1) - w_pop_c;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!redirect_in && (r_cnt < DEPTH_C)) w_next = S_REQ;
      end
      S_REQ: begin
        // An ack coincident with redirect still leaves a response in flight.
        if (mem_ack_in) w_next = redirect_in ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_in) begin
          w_next = mem_rvalid_in ? S_IDLE : S_DROP;
        end else if (mem_rvalid_in) begin
          w_next = (w_cnt_after < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (mem_rvalid_in) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
      r_pc <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      r_state <= w_next;
      if (redirect_in) begin
        r_pc <= redirect_pc_in;
      end else if ((r_state == S_REQ) && mem_ack_in) begin
        r_pc <= r_pc + INC_C;
        r_req_pc <= r_pc;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else if (redirect_in) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      r_cnt <= r_cnt + w_push_c - w_pop_c;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_fifo_insn[r_wr] <= mem_rdata_in;
      r_fifo_pc[r_wr] <= r_req_pc;
    end
  end

  assign mem_req_out = (r_state == S_REQ);
  assign mem_addr_out = r_pc;
  assign mem_rw_out = 1'b0;
  assign mem_access_size_out = 2'b10;

  assign insn_valid_out = w_valid;
  assign insn_out = w_valid ? r_fifo_insn[r_rd] : '0;
  assign pc_out = w_valid ? r_fifo_pc[r_rd] : '0;
  assign next_pc_out = pc_out + INC_C;
  assign fifo_count_out = r_cnt;

endmodule
